// File: rtl/gelato_types.sv
// Shared gelato pipeline types: instruction word, per-warp operand register, dispatcher state.
package gelato_types;

  localparam int unsigned GELATO_NUM_COLLECTORS = 4;
  localparam int unsigned GELATO_WARP_LANES     = 4;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [4:0]  warp_id;
    logic [12:0] imm;
  } inst_t;

  typedef logic [GELATO_WARP_LANES-1:0][31:0] warp_reg_t;

  typedef enum logic {StEmpty, StFull} disp_state_e;

endpackage

// File: rtl/gelato_exec_inst_if.sv
// Dispatcher-to-execute-unit payload bundle; the dispatcher is the master.
interface gelato_exec_inst_if;

  logic                  valid;
  gelato_types::inst_t     inst;
  gelato_types::warp_reg_t src1;
  gelato_types::warp_reg_t src2;
  gelato_types::warp_reg_t src3;

  modport master (output valid, inst, src1, src2, src3);
  modport slave  (input  valid, inst, src1, src2, src3);

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr with wrap, grants only when advance is high,
// and moves rr_ptr past the winner on every grant.
module gelato_rr_arbiter #(
  parameter int unsigned NUM_COLLECTORS = gelato_types::GELATO_NUM_COLLECTORS,
  parameter int unsigned PTR_W          = $clog2(NUM_COLLECTORS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_COLLECTORS-1:0] req,
  input  logic                      advance,
  output logic [NUM_COLLECTORS-1:0] grant
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             found;
  int unsigned      idx;

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_COLLECTORS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_COLLECTORS) begin
        idx = idx - NUM_COLLECTORS;
      end
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (advance && found) begin
      grant[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      rr_ptr <= (winner == PTR_W'(NUM_COLLECTORS - 1)) ? '0 : winner + PTR_W'(1);
    end
  end

endmodule

// File: rtl/gelato_exec_dispatcher.sv
// Shares one execute unit between operand collectors via a round-robin grant and a
// one-entry output register. Optional perf counters: GELATO_EXEC_DISPATCH_PERF_EN.
module gelato_exec_dispatcher
  import gelato_types::*;
#(
  parameter int unsigned NUM_COLLECTORS = GELATO_NUM_COLLECTORS,
  parameter int unsigned PTR_W          = $clog2(NUM_COLLECTORS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic      [NUM_COLLECTORS-1:0]       req_valid,
  input  inst_t     [NUM_COLLECTORS-1:0]       req_inst,
  input  warp_reg_t [NUM_COLLECTORS-1:0]       req_src1,
  input  warp_reg_t [NUM_COLLECTORS-1:0]       req_src2,
  input  warp_reg_t [NUM_COLLECTORS-1:0]       req_src3,
  output logic      [NUM_COLLECTORS-1:0]       req_grant,
  gelato_exec_inst_if.master                   exec,
  input  logic                                 exec_ready,
  output logic      [31:0]                     perf_dispatch_cnt,
  output logic      [31:0]                     perf_stall_cnt
);

  disp_state_e state_q;
  inst_t       inst_q;
  warp_reg_t   src1_q, src2_q, src3_q;

  inst_t       sel_inst;
  warp_reg_t   sel_src1, sel_src2, sel_src3;
  logic        slot_free;
  logic        advance;
  logic        grant_any;

  // Consume-and-refill in one cycle when the held payload is being accepted.
  assign slot_free = (state_q == StEmpty) || exec_ready;
  assign advance   = slot_free && !rst;
  assign grant_any = |req_grant;

  gelato_rr_arbiter #(
    .NUM_COLLECTORS (NUM_COLLECTORS),
    .PTR_W          (PTR_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (req_grant)
  );

  always_comb begin
    sel_inst = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    sel_src3 = '0;
    for (int unsigned i = 0; i < NUM_COLLECTORS; i++) begin
      if (req_grant[i]) begin
        sel_inst = req_inst[i];
        sel_src1 = req_src1[i];
        sel_src2 = req_src2[i];
        sel_src3 = req_src3[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      inst_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      src3_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (grant_any) begin
            state_q <= StFull;
          end
        end
        StFull: begin
          if (exec_ready && !grant_any) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
      // A grant implies a free slot, so loading here never overwrites a held payload.
      if (grant_any) begin
        inst_q <= sel_inst;
        src1_q <= sel_src1;
        src2_q <= sel_src2;
        src3_q <= sel_src3;
      end
    end
  end

  assign exec.valid = (state_q == StFull);
  assign exec.inst  = inst_q;
  assign exec.src1  = src1_q;
  assign exec.src2  = src2_q;
  assign exec.src3  = src3_q;

`ifdef GELATO_EXEC_DISPATCH_PERF_EN
  logic [31:0] perf_dispatch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dispatch_q <= '0;
      perf_stall_q    <= '0;
    end else if (state_q == StFull) begin
      if (exec_ready) begin
        perf_dispatch_q <= perf_dispatch_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_dispatch_cnt = perf_dispatch_q;
  assign perf_stall_cnt    = perf_stall_q;
`else
  assign perf_dispatch_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_gelato_exec_dispatcher.sv
// Bench for gelato_exec_dispatcher: fixed vector table, hand-written corner sequences,
// then randomized collector traffic checked against a behavioural model.
module tb_gelato_exec_dispatcher;
  import gelato_types::*;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic      [N-1:0]     req_valid;
  inst_t     [N-1:0]     req_inst;
  warp_reg_t [N-1:0]     req_src1, req_src2, req_src3;
  logic      [N-1:0]     req_grant;
  logic                  exec_ready;
  logic      [31:0]      perf_dispatch_cnt, perf_stall_cnt;

  gelato_exec_inst_if ex_if ();

  gelato_exec_dispatcher #(.NUM_COLLECTORS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_inst          (req_inst),
    .req_src1          (req_src1),
    .req_src2          (req_src2),
    .req_src3          (req_src3),
    .req_grant         (req_grant),
    .exec              (ex_if),
    .exec_ready        (exec_ready),
    .perf_dispatch_cnt (perf_dispatch_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic inst_t fx_inst(input int i);
    return inst_t'(32'h5A00_0000 | (32'(i) * 32'h0101));
  endfunction

  function automatic warp_reg_t fx_src(input int i, input int s);
    logic [31:0] w;
    w = 32'hC000_0000 | (32'(s) << 8) | 32'(i);
    return {w, w ^ 32'h1111_1111, w ^ 32'h2222_2222, w ^ 32'h3333_3333};
  endfunction

  function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef GELATO_EXEC_DISPATCH_PERF_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  // Behavioural model state.
  logic        m_valid;
  inst_t       m_inst;
  warp_reg_t   m_s1, m_s2, m_s3;
  int          m_ptr;
  int          m_winner;
  logic [31:0] m_disp, m_stall;
  logic [N-1:0] last_grant;

  task automatic model_reset();
    m_valid = 1'b0;
    m_inst  = '0;
    m_s1    = '0;
    m_s2    = '0;
    m_s3    = '0;
    m_ptr   = 0;
    m_disp  = '0;
    m_stall = '0;
  endtask

  task automatic model_arb(output logic [N-1:0] eg);
    int idx;
    m_winner = -1;
    if (!m_valid || exec_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (m_winner < 0 && req_valid[idx]) m_winner = idx;
      end
    end
    eg = '0;
    if (m_winner >= 0) eg[m_winner] = 1'b1;
  endtask

  task automatic model_edge();
    if (m_valid) begin
      if (exec_ready) m_disp = m_disp + 32'd1;
      else            m_stall = m_stall + 32'd1;
    end
    if (m_winner >= 0) begin
      m_valid = 1'b1;
      m_inst  = req_inst[m_winner];
      m_s1    = req_src1[m_winner];
      m_s2    = req_src2[m_winner];
      m_s3    = req_src3[m_winner];
      m_ptr   = (m_winner + 1) % N;
    end else if (m_valid && exec_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Inputs are set just after a negedge; this checks one full cycle against the model.
  task automatic cycle_chk(input string tag);
    logic [N-1:0] eg;
    #2;
    model_arb(eg);
    last_grant = req_grant;
    check({tag, " grant"}, 128'(req_grant), 128'(eg));
    @(posedge clk);
    #1;
    model_edge();
    check({tag, " valid"}, 128'(ex_if.valid), 128'(m_valid));
    if (m_valid) begin
      check({tag, " inst"}, 128'(ex_if.inst), 128'(m_inst));
      check({tag, " src1"}, ex_if.src1, m_s1);
      check({tag, " src2"}, ex_if.src2, m_s2);
      check({tag, " src3"}, ex_if.src3, m_s3);
    end
    check({tag, " perf_dispatch"}, 128'(perf_dispatch_cnt), 128'(exp_perf(m_disp)));
    check({tag, " perf_stall"}, 128'(perf_stall_cnt), 128'(exp_perf(m_stall)));
    @(negedge clk);
  endtask

  task automatic load_fixed();
    for (int i = 0; i < N; i++) begin
      req_inst[i] = fx_inst(i);
      req_src1[i] = fx_src(i, 1);
      req_src2[i] = fx_src(i, 2);
      req_src3[i] = fx_src(i, 3);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    exec_ready = 1'b0;
    @(negedge clk);
    check("rst valid", 128'(ex_if.valid), 128'(1'b0));
    check("rst inst", 128'(ex_if.inst), 128'(0));
    check("rst grant", 128'(req_grant), 128'(0));
    check("rst perf_dispatch", 128'(perf_dispatch_cnt), 128'(0));
    check("rst perf_stall", 128'(perf_stall_cnt), 128'(0));
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic [N-1:0] g;
    logic         v;
    int           src;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};   // single request, ptr -> 3
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, -1};  // drain
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, -1};  // ready while empty
    vecs[3]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};   // wrap from ptr 3
    vecs[4]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 0};   // hold
    vecs[5]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0};
    vecs[11] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, -1};

    rst        = 1'b1;
    req_valid  = '0;
    exec_ready = 1'b0;
    last_grant = '0;
    load_fixed();
    model_reset();

    // Vector table.
    do_reset();
    for (int r = 0; r < 13; r++) begin
      req_valid  = vecs[r].req;
      exec_ready = vecs[r].rdy;
      #2;
      check($sformatf("vec%0d grant", r), 128'(req_grant), 128'(vecs[r].g));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid", r), 128'(ex_if.valid), 128'(vecs[r].v));
      if (vecs[r].src >= 0) begin
        check($sformatf("vec%0d inst", r), 128'(ex_if.inst), 128'(fx_inst(vecs[r].src)));
        check($sformatf("vec%0d src3", r), ex_if.src3, fx_src(vecs[r].src, 3));
      end
      @(negedge clk);
    end

    // Rotation: all request, ready held high.
    do_reset();
    req_valid  = 4'b1111;
    exec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("rot%0d grant", k), 128'(req_grant), 128'(4'b0001 << (k % N)));
      @(posedge clk);
      #1;
      check($sformatf("rot%0d valid", k), 128'(ex_if.valid), 128'(1'b1));
      check($sformatf("rot%0d inst", k), 128'(ex_if.inst), 128'(fx_inst(k % N)));
      @(negedge clk);
    end
    check("rot perf_dispatch", 128'(perf_dispatch_cnt), 128'(exp_perf(32'd7)));

    // Backpressure holding collector 1's payload.
    req_valid = 4'b0010;
    #2;
    check("bp load grant", 128'(req_grant), 128'(4'b0010));
    @(negedge clk);
    req_valid  = 4'b1111;
    exec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      check($sformatf("bp%0d grant", k), 128'(req_grant), 128'(0));
      @(posedge clk);
      #1;
      check($sformatf("bp%0d inst", k), 128'(ex_if.inst), 128'(fx_inst(1)));
      check($sformatf("bp%0d src1", k), ex_if.src1, fx_src(1, 1));
      @(negedge clk);
    end
    check("bp perf_stall", 128'(perf_stall_cnt), 128'(exp_perf(32'd5)));
    exec_ready = 1'b1;
    #2;
    check("bp release grant", 128'(req_grant), 128'(4'b0100));
    @(posedge clk);
    #1;
    check("bp release inst", 128'(ex_if.inst), 128'(fx_inst(2)));

    // Asynchronous reset while FULL.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst valid", 128'(ex_if.valid), 128'(1'b0));
    check("midrst grant", 128'(req_grant), 128'(0));
    check("midrst inst", 128'(ex_if.inst), 128'(0));
    check("midrst perf_dispatch", 128'(perf_dispatch_cnt), 128'(0));
    check("midrst perf_stall", 128'(perf_stall_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst ptr0 grant", 128'(req_grant), 128'(4'b0001));
    @(negedge clk);

`ifdef GELATO_EXEC_DISPATCH_PERF_EN
    // Counter wrap: FULL here, preload the dispatch count just below wrap.
    req_valid  = '0;
    exec_ready = 1'b0;
    force dut.perf_dispatch_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_dispatch_q;
    exec_ready = 1'b1;
    @(posedge clk);
    #1;
    check("wrap perf_dispatch", 128'(perf_dispatch_cnt), 128'(0));
    check("wrap valid", 128'(ex_if.valid), 128'(1'b0));
    @(negedge clk);
`endif

    // Randomized collector traffic against the model.
    do_reset();
    last_grant = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_grant[i] || !req_valid[i]) begin
          req_valid[i] = last_grant[i] ? ($urandom_range(1, 0) == 1) : ($urandom_range(2, 0) == 0);
          if (req_valid[i]) begin
            req_inst[i] = inst_t'($urandom);
            req_src1[i] = {$urandom, $urandom, $urandom, $urandom};
            req_src2[i] = {$urandom, $urandom, $urandom, $urandom};
            req_src3[i] = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
      exec_ready = ($urandom_range(3, 0) != 0);
      cycle_chk($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
